// File: rtl/hls_macc_motion_driver_pkg.sv
// Shared types and defaults for the ap_ctrl_hs initiator (driver FSM states, error bit positions).
package hls_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_MISSVLD = 1;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CYC_W   = 16;
  localparam int DEF_N_IN    = 10;
  localparam int DEF_N_OUT   = 3;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/hls_macc_motion_driver_if.sv
// Command/response and core-side bundle; the driver is the master, the SoC/core environment the slave.
interface hls_macc_motion_driver_if import hls_drv_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int CYC_W  = DEF_CYC_W
);

  logic                    s_valid;
  logic                    s_ready;
  logic [N_IN*DATA_W-1:0]  s_data;

  logic [N_IN*DATA_W-1:0]  core_in;
  logic                    ap_start;
  logic                    ap_idle;
  logic                    ap_ready;
  logic                    ap_done;
  logic [N_OUT*DATA_W-1:0] core_out;
  logic [N_OUT-1:0]        core_out_vld;

  logic                    m_valid;
  logic                    m_ready;
  logic [N_OUT*DATA_W-1:0] m_data;
  logic [CYC_W-1:0]        m_cycles;
  logic [1:0]              m_err;

  modport master (
    input  s_valid, s_data,
    output s_ready,
    output core_in, ap_start,
    input  ap_idle, ap_ready, ap_done, core_out, core_out_vld,
    output m_valid, m_data, m_cycles, m_err,
    input  m_ready
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  core_in, ap_start,
    output ap_idle, ap_ready, ap_done, core_out, core_out_vld,
    input  m_valid, m_data, m_cycles, m_err,
    output m_ready
  );

endinterface

// File: rtl/hls_macc_motion_driver_watchdog.sv
// Saturating run-cycle counter; its value is the reported cycle count and it flags the TIMEOUT-th enabled cycle.
module hls_drv_watchdog #(
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CYC_W-1:0] cnt_o,
  output logic             expired_o
);

  // Count before the current cycle equals TIMEOUT-1 exactly when this is the TIMEOUT-th cycle.
  localparam logic [CYC_W:0] LIMIT = (CYC_W+1)'(TIMEOUT - 1);

  logic [CYC_W-1:0] cnt_q;
  logic [CYC_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign expired_o = en_i && ({1'b0, cnt_q} >= LIMIT);

endmodule

// File: rtl/hls_macc_motion_driver.sv
// ap_ctrl_hs initiator: accepts one operand set, runs the core with frozen inputs, returns results/cycles/errors.
// One-cycle bubble between jobs because s_ready is only raised from IDLE.
module hls_macc_motion_driver import hls_drv_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_IN    = DEF_N_IN,
  parameter int N_OUT   = DEF_N_OUT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CYC_W   = DEF_CYC_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  hls_macc_motion_driver_if.master bus
);

  state_t                  state_q, state_d;
  logic [N_IN*DATA_W-1:0]  core_in_q, core_in_d;
  logic                    ap_start_q, ap_start_d;
  logic [N_OUT*DATA_W-1:0] m_data_q, m_data_d;
  logic [N_OUT-1:0]        mask_q, mask_d;
  logic [1:0]              m_err_q, m_err_d;

  logic                    s_ready_w;
  logic                    wd_clr;
  logic                    wd_en;
  logic                    wd_expired;
  logic [CYC_W-1:0]        wd_cnt;

  hls_drv_watchdog #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (ap_clk),
    .rst_i     (ap_rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .cnt_o     (wd_cnt),
    .expired_o (wd_expired)
  );

  assign s_ready_w = (state_q == IDLE) && bus.ap_idle && !ap_rst;

  always_comb begin
    state_d    = state_q;
    core_in_d  = core_in_q;
    ap_start_d = ap_start_q;
    m_data_d   = m_data_q;
    mask_d     = mask_q;
    m_err_d    = m_err_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.s_valid && s_ready_w) begin
          core_in_d  = bus.s_data;
          ap_start_d = 1'b1;
          mask_d     = '0;
          m_err_d    = '0;
          wd_clr     = 1'b1;
          state_d    = RUN;
        end
      end

      RUN: begin
        wd_en = 1'b1;
        if (bus.ap_ready) begin
          ap_start_d = 1'b0;
        end
        for (int k = 0; k < N_OUT; k++) begin
          if (bus.core_out_vld[k]) begin
            m_data_d[k*DATA_W +: DATA_W] = bus.core_out[k*DATA_W +: DATA_W];
            mask_d[k]                    = 1'b1;
          end
        end
        // Done has priority over a watchdog expiry in the same cycle.
        if (bus.ap_done) begin
          m_err_d              = '0;
          m_err_d[ERR_MISSVLD] = ~&(mask_q | bus.core_out_vld);
          ap_start_d           = 1'b0;
          state_d              = RESP;
        end else if (wd_expired) begin
          m_err_d              = '0;
          m_err_d[ERR_TIMEOUT] = 1'b1;
          m_data_d             = '0;
          ap_start_d           = 1'b0;
          state_d              = RESP;
        end
      end

      RESP: begin
        if (bus.m_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        ap_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      core_in_q  <= '0;
      ap_start_q <= 1'b0;
      m_data_q   <= '0;
      mask_q     <= '0;
      m_err_q    <= '0;
    end else begin
      state_q    <= state_d;
      core_in_q  <= core_in_d;
      ap_start_q <= ap_start_d;
      m_data_q   <= m_data_d;
      mask_q     <= mask_d;
      m_err_q    <= m_err_d;
    end
  end

  assign bus.s_ready  = s_ready_w;
  assign bus.core_in  = core_in_q;
  assign bus.ap_start = ap_start_q;
  assign bus.m_valid  = (state_q == RESP);
  assign bus.m_data   = m_data_q;
  assign bus.m_cycles = wd_cnt;
  assign bus.m_err    = m_err_q;

endmodule
